// File: rtl/vga_pkg.sv
// Shared types and frame geometry for the VGA serial display pixel path.
package vga_pkg;

    typedef enum logic [1:0] {
        F_IDLE    = 2'd0,
        F_REQ     = 2'd1,
        F_RELEASE = 2'd2
    } fetch_state_t;

    localparam int WORD_W          = 32;
    localparam int PIX_W           = 24;
    localparam int H_PIX           = 480;
    localparam int V_PIX           = 360;
    localparam int WORDS_PER_FRAME = H_PIX * V_PIX * PIX_W / WORD_W;

endpackage

// File: rtl/pixel_fifo.sv
// Small pixel FIFO with flush. The head entry is read straight out of the
// register array, so a pop can load the consumer's register in the same cycle.
module pixel_fifo #(
    parameter int PIX_W      = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [PIX_W-1:0] din,
    input  logic             pop,
    output logic [PIX_W-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [PIX_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally (power-of-two depth); occupancy tracks push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_unpacker.sv
// Fetches 32-bit words from the RAM reader, unpacks them MSB-first into
// 24-bit RGB pixels through a bit accumulator, and hands one pixel per
// pix_ce strobe to the DAC during the visible area.
module pixel_unpacker #(
    parameter int WORD_W     = vga_pkg::WORD_W,
    parameter int PIX_W      = vga_pkg::PIX_W,
    parameter int H_PIX      = vga_pkg::H_PIX,
    parameter int V_PIX      = vga_pkg::V_PIX,
    parameter int REQ_HOLD   = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_ce,
    input  logic              active,
    input  logic [WORD_W-1:0] ram_data,
    output logic              refresh_data,
    output logic              visible,
    output logic [PIX_W-1:0]  pixel_rgb,
    output logic              underflow
);

    import vga_pkg::*;

    localparam int ACC_W = WORD_W + PIX_W;
    localparam int AB_W  = $clog2(ACC_W + 1);
    localparam int WPF_I = H_PIX * V_PIX * PIX_W / WORD_W;
    localparam int WF_W  = $clog2(WPF_I + 1);
    localparam int HC_W  = (REQ_HOLD > 1) ? $clog2(REQ_HOLD) : 1;

    localparam logic [WF_W-1:0] WPF       = WF_W'(WPF_I);
    localparam logic [AB_W-1:0] ACC_PIX   = AB_W'(PIX_W);
    localparam logic [AB_W-1:0] ACC_WORD  = AB_W'(WORD_W);
    localparam logic [AB_W-1:0] ROOM      = AB_W'(ACC_W - WORD_W);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(REQ_HOLD - 1);

    fetch_state_t     state;
    logic [HC_W-1:0]  hold_cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [AB_W-1:0]  acc_bits;
    logic [AB_W-1:0]  acc_bits_nxt;
    logic [WF_W-1:0]  words_fetched;
    logic             capture;
    logic             extract;
    logic             fetch_ok;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [PIX_W-1:0] fifo_head;

    assign refresh_data = (state == F_REQ);
    assign visible      = (state != F_IDLE);

    // Capture on the last hold cycle; extraction yields to capture so the
    // accumulator never appends and shifts in the same cycle.
    assign capture  = (state == F_REQ) && (hold_cnt == HOLD_LAST) && !frame_start;
    assign extract  = (acc_bits >= ACC_PIX) && !fifo_full && !capture && !frame_start;
    assign fifo_pop = pix_ce && active && !fifo_empty && !frame_start;

    // A new request is allowed only if the word will still fit once it lands;
    // looking at next-cycle occupancy lets RELEASE chain straight into REQ.
    assign fetch_ok = (words_fetched < WPF) && (acc_bits_nxt <= ROOM);

    // Accumulator next state: new words land just below the valid MSB-aligned bits.
    always_comb begin
        acc_nxt      = acc;
        acc_bits_nxt = acc_bits;
        if (frame_start) begin
            acc_nxt      = '0;
            acc_bits_nxt = '0;
        end else if (capture) begin
            acc_nxt      = acc | ({ram_data, {PIX_W{1'b0}}} >> acc_bits);
            acc_bits_nxt = acc_bits + ACC_WORD;
        end else if (extract) begin
            acc_nxt      = acc << PIX_W;
            acc_bits_nxt = acc_bits - ACC_PIX;
        end
    end

    // Fetch FSM: hold the request for REQ_HOLD cycles, then one release cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= F_IDLE;
            hold_cnt <= '0;
        end else if (frame_start) begin
            state    <= (state == F_REQ) ? F_RELEASE : F_IDLE;
            hold_cnt <= '0;
        end else begin
            case (state)
                F_IDLE: begin
                    if (fetch_ok)
                        state <= F_REQ;
                end
                F_REQ: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= F_RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                F_RELEASE: begin
                    state <= fetch_ok ? F_REQ : F_IDLE;
                end
                default: begin
                    state    <= F_IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Accumulator and saturating per-frame word counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc           <= '0;
            acc_bits      <= '0;
            words_fetched <= '0;
        end else begin
            acc      <= acc_nxt;
            acc_bits <= acc_bits_nxt;
            if (frame_start)
                words_fetched <= '0;
            else if (capture && (words_fetched != WPF))
                words_fetched <= words_fetched + WF_W'(1);
        end
    end

    // Output register: pop on an active strobe, blank otherwise, flag starvation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_rgb <= '0;
            underflow <= 1'b0;
        end else if (frame_start) begin
            pixel_rgb <= '0;
            underflow <= 1'b0;
        end else if (pix_ce) begin
            if (active && !fifo_empty) begin
                pixel_rgb <= fifo_head;
            end else begin
                pixel_rgb <= '0;
                if (active)
                    underflow <= 1'b1;
            end
        end
    end

    pixel_fifo #(
        .PIX_W      (PIX_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (frame_start),
        .push  (extract),
        .din   (acc[ACC_W-1 -: PIX_W]),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_pixel_unpacker.sv
// Bench for pixel_unpacker with a small frame (8x3 pixels, 18 words) and a
// behavioural RAM reader; pixel outputs are checked through a scoreboard.
module tb_pixel_unpacker;

    localparam int WPF = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_ce = 1'b0;
    logic        active = 1'b0;
    logic [31:0] ram_data = '0;
    logic        refresh_data;
    logic        visible;
    logic [23:0] pixel_rgb;
    logic        underflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pixel_unpacker #(
        .WORD_W     (32),
        .PIX_W      (24),
        .H_PIX      (8),
        .V_PIX      (3),
        .REQ_HOLD   (3),
        .FIFO_DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .pix_ce       (pix_ce),
        .active       (active),
        .ram_data     (ram_data),
        .refresh_data (refresh_data),
        .visible      (visible),
        .pixel_rgb    (pixel_rgb),
        .underflow    (underflow)
    );

    // Reader model: latches the addressed word when a request rises and
    // presents it on data_out two cycles after the request is first seen.
    logic [31:0] mem [WPF];
    logic [31:0] rd_stage = '0;
    int          rd_addr = 0;
    logic        ref_q = 1'b0;
    int          req_cnt = 0;

    always @(posedge clk) begin
        if (frame_start) begin
            rd_addr <= 0;
            req_cnt <= 0;
        end else if (refresh_data && !ref_q) begin
            rd_stage <= mem[rd_addr % WPF];
            rd_addr  <= rd_addr + 1;
            req_cnt  <= req_cnt + 1;
        end
        ram_data <= rd_stage;
        ref_q    <= refresh_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe while enabled retires one expected pixel.
    logic [23:0] exp_q [$];
    logic [23:0] exp_pix;
    bit          sb_en = 1'b1;

    always @(posedge clk) begin
        if (pix_ce && sb_en) begin
            #2;
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                exp_pix = exp_q.pop_front();
                check("pixel", {8'h0, pixel_rgb}, {8'h0, exp_pix});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic act, input logic [23:0] exp);
        active = act;
        pix_ce = 1'b1;
        exp_q.push_back(exp);
        tick();
        pix_ce = 1'b0;
        repeat (3) tick();
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Waits for the start of a fresh request, bounded.
    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (refresh_data && n < 60) begin
            tick();
            n++;
        end
        while (!refresh_data && n < 120) begin
            tick();
            n++;
        end
        check(name, {31'd0, refresh_data}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        mem[0] = 32'hAABBCCDD;
        mem[1] = 32'h11223344;
        mem[2] = 32'h55667788;
        for (int i = 3; i < WPF; i++) mem[i] = 32'h0;

        // Reset state
        repeat (3) tick();
        check("rst_refresh", {31'd0, refresh_data}, 32'd0);
        check("rst_visible", {31'd0, visible}, 32'd0);
        check("rst_pixel", {8'h0, pixel_rgb}, 32'd0);
        check("rst_underflow", {31'd0, underflow}, 32'd0);

        // Strobe straight out of reset: FIFO empty -> blank pixel, underflow set
        rst = 1'b1;
        strobe(1'b1, 24'h0);
        check("early_underflow", {31'd0, underflow}, 32'd1);

        // Asynchronous reset in the middle of a request
        wait_req("t1_req");
        tick();
        #3;
        rst = 1'b0;
        #1;
        check("arst_refresh", {31'd0, refresh_data}, 32'd0);
        check("arst_visible", {31'd0, visible}, 32'd0);
        check("arst_pixel", {8'h0, pixel_rgb}, 32'd0);
        check("arst_underflow", {31'd0, underflow}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        fstart();

        // Handshake: three request cycles, one release, then the next request
        wait_req("t2_req");
        for (int k = 0; k < 3; k++) begin
            check("hs_refresh_hi", {31'd0, refresh_data}, 32'd1);
            check("hs_visible_hi", {31'd0, visible}, 32'd1);
            tick();
        end
        check("hs_release_refresh", {31'd0, refresh_data}, 32'd0);
        check("hs_release_visible", {31'd0, visible}, 32'd1);
        tick();
        check("hs_next_req", {31'd0, refresh_data}, 32'd1);

        // Unpacking, with a blanking strobe that must not pop
        strobe(1'b1, 24'hAABBCC);
        strobe(1'b0, 24'h000000);
        strobe(1'b1, 24'hDD1122);
        strobe(1'b1, 24'h334455);
        strobe(1'b1, 24'h667788);
        check("held_pixel", {8'h0, pixel_rgb}, 32'h00667788);

        // Underflow: strobe every cycle until the frame's words run dry
        sb_en  = 1'b0;
        active = 1'b1;
        pix_ce = 1'b1;
        repeat (200) tick();
        pix_ce = 1'b0;
        check("uf_pixel", {8'h0, pixel_rgb}, 32'd0);
        check("uf_flag", {31'd0, underflow}, 32'd1);
        repeat (10) tick();
        check("uf_sticky", {31'd0, underflow}, 32'd1);
        sb_en = 1'b1;

        // New frame with throw-away data, then abort it mid-request
        for (int i = 0; i < WPF; i++) mem[i] = 32'hDEAD0000 | 32'(i);
        fstart();
        check("fs_clears_uf", {31'd0, underflow}, 32'd0);
        check("fs_clears_pixel", {8'h0, pixel_rgb}, 32'd0);
        repeat (20) tick();
        for (int i = 0; i < WPF; i++)
            mem[i] = {8'(16 + 4*i), 8'(17 + 4*i), 8'(18 + 4*i), 8'(19 + 4*i)};
        wait_req("t5_req");
        tick();
        fstart();
        check("flush_refresh", {31'd0, refresh_data}, 32'd0);
        check("flush_visible", {31'd0, visible}, 32'd1);

        // Full frame: 18 words -> 24 pixels, byte stream 0x10,0x11,...
        repeat (80) tick();
        check("preroll_uf", {31'd0, underflow}, 32'd0);
        for (int k = 0; k < 24; k++) begin
            b = 8'(16 + 3*k);
            strobe(1'b1, {b, b + 8'd1, b + 8'd2});
        end
        check("frame_uf", {31'd0, underflow}, 32'd0);
        check("last_pixel", {8'h0, pixel_rgb}, 32'h00555657);
        strobe(1'b1, 24'h0);
        check("frame_end_uf", {31'd0, underflow}, 32'd1);
        check("req_count", 32'(req_cnt), 32'd18);
        repeat (40) tick();
        check("req_count_idle", 32'(req_cnt), 32'd18);
        check("no_req_after_end", {31'd0, refresh_data}, 32'd0);

        // Next frame_start restarts fetching
        fstart();
        wait_req("restart_req");

        #5;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
